// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode hex display driver with
// per-digit decimal points, leading-zero blanking and PWM brightness.
// New data is latched into shadow registers on load and promoted to the
// active (displayed) registers only at a frame boundary, so a scan never tears.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BRIGHT_W    = 4,
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic [IDX_W-1:0]        scan_idx
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SLICE = REFRESH_DIV >> BRIGHT_W;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [4*NUM_DIGITS-1:0] sh_value,  act_value;
    logic [NUM_DIGITS-1:0]   sh_dp,     act_dp;
    logic                    sh_lz,     act_lz;
    logic [BRIGHT_W-1:0]     sh_bright, act_bright;
    // Active registers hold nothing displayable until a load has reached them.
    logic                    sh_valid,  act_valid;

    logic                    wrap_c, frame_c, on_c;
    logic [3:0]              nib_c;
    logic                    dp_bit_c, blank_bit_c, zero_run_c;
    logic [NUM_DIGITS-1:0]   blank_c, anode_c;
    logic [6:0]              cathode_c;
    logic                    dp_c;

    // Active-low gfedcba pattern for a hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Slot timing: wrap, frame boundary and the PWM on-window (slot cycle 0 is dead time).
    always_comb begin
        wrap_c  = (prescaler == PRE_MAX);
        frame_c = wrap_c && (scan_idx == IDX_MAX);
        on_c    = act_valid && (prescaler != '0) &&
                  (32'(prescaler) < (32'(act_bright) + 32'd1) * SLICE);
    end

    // Select the current digit and work out leading-zero blanking from the top down.
    always_comb begin
        nib_c       = '0;
        dp_bit_c    = 1'b0;
        blank_bit_c = 1'b0;
        blank_c     = '0;
        zero_run_c  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c & (act_value[4*i +: 4] == 4'h0);
            if (i > 0) blank_c[i] = act_lz & zero_run_c;
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scan_idx == IDX_W'(i)) begin
                nib_c       = act_value[4*i +: 4];
                dp_bit_c    = act_dp[i];
                blank_bit_c = blank_c[i];
            end
        end
    end

    // Next anode/cathode/dp; a blanked digit still drives its anode if its point is lit.
    always_comb begin
        anode_c   = '1;
        cathode_c = 7'h7F;
        dp_c      = 1'b1;
        if (on_c && (!blank_bit_c || dp_bit_c)) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (scan_idx == IDX_W'(i)) anode_c[i] = 1'b0;
            end
            if (!blank_bit_c) cathode_c = seg7(nib_c);
            dp_c = ~dp_bit_c;
        end
    end

    // Counters, shadow/active register pair and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            scan_idx   <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_lz      <= 1'b0;
            sh_bright  <= '0;
            sh_valid   <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
            act_bright <= '0;
            act_valid  <= 1'b0;
            anode      <= '1;
            cathode    <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            prescaler <= wrap_c ? '0 : prescaler + 1'b1;
            if (wrap_c) scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
            if (load) begin
                sh_value  <= value;
                sh_dp     <= dp_in;
                sh_lz     <= lz_en;
                sh_bright <= brightness;
                sh_valid  <= 1'b1;
            end
            if (frame_c) begin
                act_value  <= sh_value;
                act_dp     <= sh_dp;
                act_lz     <= sh_lz;
                act_bright <= sh_bright;
                act_valid  <= sh_valid;
            end
            anode   <= anode_c;
            cathode <= cathode_c;
            dp      <= dp_c;
        end
    end

endmodule
